// File: rtl/irq_pending_latch.sv
// irq_pending_latch: sticky interrupt pending latch with per-line edge/level capture,
// indexed acknowledge, output masking and lost-edge overflow flags.
module irq_pending_latch #(
   parameter int INPUT_LINES = 4,
   parameter int IDX_W = $clog2(INPUT_LINES)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [INPUT_LINES-1:0] irq_in,
   input  logic [INPUT_LINES-1:0] edge_mode,
   input  logic [INPUT_LINES-1:0] mask,
   input  logic                   ack_valid,
   input  logic [IDX_W-1:0]       ack_index,
   input  logic                   ovf_clear,
   output logic [INPUT_LINES-1:0] pending,
   output logic [INPUT_LINES-1:0] req_vec,
   output logic                   any_req,
   output logic [INPUT_LINES-1:0] overflow
);
   logic [INPUT_LINES-1:0] prev, set_ev, ack_ev;
   if (INPUT_LINES < 2) begin : g_chk
      $error("irq_pending_latch: INPUT_LINES must be at least 2");
   end
   // out-of-range indices match no line, so they acknowledge nothing
   for (genvar i = 0; i < INPUT_LINES; i++) begin : g_ack
      assign ack_ev[i] = ack_valid && (ack_index == IDX_W'(i));
   end
   assign set_ev  = irq_in & ~(edge_mode & prev);
   assign req_vec = pending & mask;
   assign any_req = |req_vec;
   always_ff @(posedge clk) begin
      if (rst) begin
         prev     <= '0;
         pending  <= '0;
         overflow <= '0;
      end else begin
         prev     <= irq_in;
         pending  <= set_ev | (pending & ~ack_ev);
         overflow <= (overflow & ~{INPUT_LINES{ovf_clear}}) | (edge_mode & set_ev & pending & ~ack_ev);
      end
   end
endmodule

// File: tb/tb_irq_pending_latch.sv
// tb_irq_pending_latch: directed scenarios plus randomized run against a per-line behavioural model.
module tb_irq_pending_latch;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] irq_in = '0, edge_mode = '0, mask = '0;
   logic       ack_valid = 1'b0, ovf_clear = 1'b0;
   logic [2:0] ack_index = '0;
   logic [3:0] pending, req_vec, overflow;
   logic       any_req;
   int total = 0, bad = 0;

   irq_pending_latch #(.INPUT_LINES(4), .IDX_W(3)) dut (
      .clk(clk), .rst(rst), .irq_in(irq_in), .edge_mode(edge_mode), .mask(mask),
      .ack_valid(ack_valid), .ack_index(ack_index), .ovf_clear(ovf_clear),
      .pending(pending), .req_vec(req_vec), .any_req(any_req), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; irq_in = 4'hF; edge_mode = 4'h0; mask = 4'hF; ack_valid = 1'b0; ovf_clear = 1'b0;
      tick(); tick();
      total++; if (pending !== 4'h0) begin bad++; $display("FAIL reset_pending got=%h exp=0", pending); end
      total++; if (overflow !== 4'h0) begin bad++; $display("FAIL reset_overflow got=%h exp=0", overflow); end
      total++; if (req_vec !== 4'h0) begin bad++; $display("FAIL reset_req_vec got=%h exp=0", req_vec); end
      total++; if (any_req !== 1'b0) begin bad++; $display("FAIL reset_any_req got=%b exp=0", any_req); end
      irq_in = 4'h0; rst = 1'b0;
      tick();
   endtask

   task automatic test_edge_pulse();
      edge_mode = 4'hF; mask = 4'hF; irq_in = 4'b0100;
      tick();
      irq_in = 4'h0;
      total++; if (pending !== 4'b0100) begin bad++; $display("FAIL pulse_pending got=%h exp=4", pending); end
      total++; if (req_vec !== 4'b0100) begin bad++; $display("FAIL pulse_req_vec got=%h exp=4", req_vec); end
      total++; if (any_req !== 1'b1) begin bad++; $display("FAIL pulse_any_req got=%b exp=1", any_req); end
      tick();
      total++; if (pending !== 4'b0100) begin bad++; $display("FAIL pulse_sticky got=%h exp=4", pending); end
      ack_valid = 1'b1; ack_index = 3'd2;
      tick();
      ack_valid = 1'b0;
      total++; if (pending !== 4'h0) begin bad++; $display("FAIL pulse_ack got=%h exp=0", pending); end
      total++; if (any_req !== 1'b0) begin bad++; $display("FAIL pulse_ack_any got=%b exp=0", any_req); end
   endtask

   task automatic test_level_reack();
      edge_mode = 4'h0; irq_in = 4'b0001;
      tick();
      total++; if (pending !== 4'b0001) begin bad++; $display("FAIL level_set got=%h exp=1", pending); end
      ack_valid = 1'b1; ack_index = 3'd0;
      tick();
      total++; if (pending[0] !== 1'b1) begin bad++; $display("FAIL level_reset_wins got=%b exp=1", pending[0]); end
      tick();
      total++; if (pending[0] !== 1'b1) begin bad++; $display("FAIL level_reset_wins2 got=%b exp=1", pending[0]); end
      total++; if (overflow !== 4'h0) begin bad++; $display("FAIL level_no_ovf got=%h exp=0", overflow); end
      irq_in = 4'h0;
      tick();
      ack_valid = 1'b0;
      total++; if (pending[0] !== 1'b0) begin bad++; $display("FAIL level_ack_low got=%b exp=0", pending[0]); end
   endtask

   task automatic test_overflow();
      edge_mode = 4'hF; irq_in = 4'b1000;
      tick();
      irq_in = 4'h0;
      tick();
      total++; if (overflow !== 4'h0) begin bad++; $display("FAIL ovf_first_edge got=%h exp=0", overflow); end
      irq_in = 4'b1000;
      tick();
      irq_in = 4'h0;
      total++; if (overflow !== 4'b1000) begin bad++; $display("FAIL ovf_second_edge got=%h exp=8", overflow); end
      ovf_clear = 1'b1;
      tick();
      ovf_clear = 1'b0;
      total++; if (overflow !== 4'h0) begin bad++; $display("FAIL ovf_clear got=%h exp=0", overflow); end
      irq_in = 4'b1000; ovf_clear = 1'b1;
      tick();
      irq_in = 4'h0;
      total++; if (overflow !== 4'b1000) begin bad++; $display("FAIL ovf_new_wins got=%h exp=8", overflow); end
      ack_valid = 1'b1; ack_index = 3'd3;
      tick();
      ack_valid = 1'b0; ovf_clear = 1'b0;
      total++; if (overflow !== 4'h0 || pending !== 4'h0) begin bad++; $display("FAIL ovf_cleanup got=%h/%h exp=0/0", overflow, pending); end
   endtask

   task automatic test_mask();
      mask = 4'h0; edge_mode = 4'hF; irq_in = 4'b0110;
      tick();
      irq_in = 4'h0;
      tick();
      total++; if (pending !== 4'b0110) begin bad++; $display("FAIL mask_pending got=%h exp=6", pending); end
      total++; if (req_vec !== 4'h0) begin bad++; $display("FAIL mask_req_vec got=%h exp=0", req_vec); end
      total++; if (any_req !== 1'b0) begin bad++; $display("FAIL mask_any_req got=%b exp=0", any_req); end
      mask = 4'b0010;
      #1;
      total++; if (req_vec !== 4'b0010) begin bad++; $display("FAIL unmask_req_vec got=%h exp=2", req_vec); end
      total++; if (any_req !== 1'b1) begin bad++; $display("FAIL unmask_any_req got=%b exp=1", any_req); end
      ack_valid = 1'b1; ack_index = 3'd1;
      tick();
      ack_index = 3'd2;
      tick();
      ack_valid = 1'b0; mask = 4'hF;
      total++; if (pending !== 4'h0) begin bad++; $display("FAIL mask_cleanup got=%h exp=0", pending); end
   endtask

   task automatic test_set_ack_same();
      edge_mode = 4'hF; irq_in = 4'b0010;
      tick();
      irq_in = 4'h0;
      tick();
      irq_in = 4'b0010; ack_valid = 1'b1; ack_index = 3'd1;
      tick();
      irq_in = 4'h0; ack_valid = 1'b0;
      total++; if (pending !== 4'b0010) begin bad++; $display("FAIL same_cycle_pending got=%h exp=2", pending); end
      total++; if (overflow[1] !== 1'b0) begin bad++; $display("FAIL same_cycle_ovf got=%b exp=0", overflow[1]); end
      ack_valid = 1'b1; ack_index = 3'd5;
      tick();
      ack_valid = 1'b0;
      total++; if (pending !== 4'b0010 || overflow !== 4'h0) begin bad++; $display("FAIL ack_out_of_range got=%h/%h exp=2/0", pending, overflow); end
      ack_valid = 1'b1; ack_index = 3'd0;
      tick();
      ack_valid = 1'b0;
      total++; if (pending !== 4'b0010) begin bad++; $display("FAIL ack_non_pending got=%h exp=2", pending); end
   endtask

   task automatic test_reset_mid();
      edge_mode = 4'hF; irq_in = 4'hF;
      tick();
      irq_in = 4'h0;
      tick();
      irq_in = 4'b0011;
      tick();
      total++; if (pending !== 4'hF || overflow !== 4'h3) begin bad++; $display("FAIL mid_setup got=%h/%h exp=f/3", pending, overflow); end
      rst = 1'b1; irq_in = 4'b0100;
      tick();
      total++; if (pending !== 4'h0 || overflow !== 4'h0) begin bad++; $display("FAIL mid_reset got=%h/%h exp=0/0", pending, overflow); end
      total++; if (req_vec !== 4'h0 || any_req !== 1'b0) begin bad++; $display("FAIL mid_reset_req got=%h/%b exp=0/0", req_vec, any_req); end
      tick();
      rst = 1'b0;
      tick();
      total++; if (pending !== 4'b0100) begin bad++; $display("FAIL held_through_reset got=%h exp=4", pending); end
      irq_in = 4'h0;
   endtask

   task automatic test_random();
      bit mp[4], mo[4], mv[4];
      logic [3:0] ep, eo;
      for (int c = 0; c < 400; c++) begin
         rst = (c == 0) || ($urandom_range(0, 40) == 0);
         irq_in = 4'($urandom);
         if (c % 16 == 0) edge_mode = 4'($urandom);
         mask = 4'($urandom);
         ack_valid = 1'($urandom_range(0, 1));
         ack_index = 3'($urandom_range(0, 7));
         ovf_clear = ($urandom_range(0, 9) == 0);
         for (int i = 0; i < 4; i++) begin
            bit s, a;
            s = edge_mode[i] ? (irq_in[i] && !mv[i]) : irq_in[i];
            a = ack_valid && (int'(ack_index) == i);
            if (rst) begin
               mp[i] = 0; mo[i] = 0; mv[i] = 0;
            end else begin
               if (edge_mode[i] && s && mp[i] && !a) mo[i] = 1;
               else if (ovf_clear) mo[i] = 0;
               mp[i] = s ? 1'b1 : (a ? 1'b0 : mp[i]);
               mv[i] = irq_in[i];
            end
         end
         tick();
         for (int i = 0; i < 4; i++) begin
            ep[i] = mp[i];
            eo[i] = mo[i];
         end
         total++; if (pending !== ep) begin bad++; $display("FAIL rand_pending cyc=%0d got=%h exp=%h", c, pending, ep); end
         total++; if (overflow !== eo) begin bad++; $display("FAIL rand_overflow cyc=%0d got=%h exp=%h", c, overflow, eo); end
         total++; if (req_vec !== (ep & mask)) begin bad++; $display("FAIL rand_req_vec cyc=%0d got=%h exp=%h", c, req_vec, ep & mask); end
         total++; if (any_req !== ((ep & mask) != 4'h0)) begin bad++; $display("FAIL rand_any_req cyc=%0d got=%b exp=%b", c, any_req, (ep & mask) != 4'h0); end
      end
      rst = 1'b0; ack_valid = 1'b0; ovf_clear = 1'b0;
   endtask

   initial begin
      test_reset();
      test_edge_pulse();
      test_level_reack();
      test_overflow();
      test_mask();
      test_set_ack_same();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/irq_pending_latch.md
IRQ_PENDING_LATCH -- requirements
Module: irq_pending_latch

Interface
REQ-001 SHALL have parameter INPUT_LINES, default 4, number of request lines; elaboration SHALL raise $error if INPUT_LINES < 2.
REQ-002 SHALL have parameter IDX_W, default $clog2(INPUT_LINES), width of the acknowledge index.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port irq_in  input  INPUT_LINES  raw request lines, already synchronous to clk.
REQ-006 SHALL have port edge_mode  input  INPUT_LINES  per line: 1 = rising-edge capture, 0 = level capture.
REQ-007 SHALL have port mask  input  INPUT_LINES  per line: 1 = enabled onto req_vec.
REQ-008 SHALL have port ack_valid  input  1  acknowledge strobe from the downstream priority encoder stage.
REQ-009 SHALL have port ack_index  input  IDX_W  index of the line being acknowledged.
REQ-010 SHALL have port ovf_clear  input  1  clears all overflow flags.
REQ-011 SHALL have port pending  output  INPUT_LINES  registered sticky pending bits.
REQ-012 SHALL have port req_vec  output  INPUT_LINES  pending & mask; this vector feeds the priority encoder data input.
REQ-013 SHALL have port any_req  output  1  OR-reduction of req_vec.
REQ-014 SHALL have port overflow  output  INPUT_LINES  registered sticky lost-edge flags.

Function
REQ-015 SHALL hold a register prev capturing irq_in every cycle.
REQ-016 Set event for line i SHALL be irq_in[i] & ~prev[i] when edge_mode[i]=1, and irq_in[i] when edge_mode[i]=0.
REQ-017 Ack event for line i SHALL be ack_valid & (ack_index == i); ack_index >= INPUT_LINES SHALL have no effect.
REQ-018 Next pending[i] SHALL be 1 on a set event, else 0 on an ack event, else hold; a set and an ack in the same cycle SHALL leave pending[i]=1.
REQ-019 Latency: a set event sampled at edge k SHALL appear on pending, req_vec and any_req immediately after edge k, i.e. one cycle.
REQ-020 Ack at edge k SHALL clear pending[i] immediately after edge k.
REQ-021 A level-mode line held high SHALL re-set pending in the cycle after an ack.
REQ-022 overflow[i] SHALL set when edge_mode[i]=1, a set event occurs, pending[i]=1, and there is no same-cycle ack event for i.
REQ-023 ovf_clear SHALL zero all overflow bits; a simultaneous new overflow condition on line i SHALL win, leaving overflow[i]=1.
REQ-024 mask SHALL NOT gate capture; masked lines SHALL still latch into pending and SHALL appear on req_vec once unmasked.
REQ-025 req_vec and any_req SHALL be combinational from the pending register and the mask input only, with no path from irq_in.
REQ-026 Acking a non-pending line SHALL be a no-op.
REQ-027 A change of edge_mode SHALL affect only set events from the next edge onward; pending SHALL be unchanged by the change itself.

Reset
REQ-028 While rst=1 at a clock edge, pending, overflow and prev SHALL be cleared to 0; rst SHALL take priority over all set, ack and clear events.
REQ-029 Because prev resets to 0, an edge-mode line held high across reset deassertion SHALL register a set event at the first edge with rst=0.
REQ-030 During reset, req_vec SHALL be 0 and any_req SHALL be 0.

Verification
REQ-031 Reset then a one-cycle irq_in=4'b0100 pulse with edge_mode=4'hF and mask=4'hF -> pending=4'b0100, req_vec=4'b0100 and any_req=1 one cycle later; the bit stays set until ack_valid=1 with ack_index=2 clears it the following cycle.
REQ-032 Level mode on line 0 (edge_mode=4'h0) with irq_in[0] held high and ack of index 0 -> pending[0] drops for zero visible cycles (re-set wins); irq_in[0] low with ack -> pending[0]=0.
REQ-033 Edge mode: two rising edges on line 3 with no ack between them -> overflow=4'b1000; ovf_clear=1 -> overflow=0 next cycle.
REQ-034 mask=4'b0000 with pulses on lines 1 and 2 -> pending=4'b0110, req_vec=0 and any_req=0; then mask=4'b0010 -> req_vec=4'b0010 in the same cycle.
REQ-035 Same-cycle set and ack on line 1 -> pending[1]=1 and overflow[1]=0; ack_index=5 with INPUT_LINES=4 and IDX_W=3 -> no state change.
REQ-036 rst asserted mid-operation with pending=4'hF and overflow=4'h3 -> both are 0 after one edge; irq_in[2] held high in edge mode through deassertion -> pending[2]=1 one cycle after release.
